load_store_unit: RTL
====================

# load_store_unit

Initiator side of the data-memory bus. Sits between the CPU execute stage and the data memory. Takes one RV32 load/store request at a time and drives `memread`/`memwrite`/`byte_enable`/`addr`/`wr_data` to memory. Splits misaligned RAM accesses into two word beats, un-swaps RAM read lanes, then sign- or zero-extends the result and returns it with a one-cycle response pulse.

## Interface
Parameters:
- `RAM_BASE`, default 32'h80000000: byte base of data RAM.
- `RAM_BYTES`, default 4096: RAM size in bytes; the region is [RAM_BASE, RAM_BASE+RAM_BYTES).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  high only in IDLE; a request is accepted when `req_valid && req_ready`.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32 width code. 000 B, 001 H, 010 W, 100 BU, 101 HU. BU and HU are legal for loads only.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  extended load result; 0 for stores and faults. Holds its value until the next response.
- `resp_fault`  out  1  qualified by `resp_valid`.
- `memread`, `memwrite`  out  1 each  memory strobes.
- `byte_enable`  out  4  per-lane write enables; bit i drives `wr_data[8i+7:8i]`.
- `addr`  out  32  word-aligned beat address.
- `wr_data`  out  32  lane-positioned store data.
- `mem_out_data`  in  32  combinational read data from memory.

## Operation
Address decode:
- RAM:
  - Addresses inside the RAM region.
  - Any width, any alignment.
  - Read lanes are reversed: `mem_out_data[31:24]` is lane 0 and `mem_out_data[7:0]` is lane 3. The LSU byte-reverses RAM read data before use.
- MMIO:
  - Loads allowed at 0x00100000, 0x00100004, 0x00100010 and 0x00100014.
  - Stores allowed only at 0x00100014.
  - Word width (010) only; MMIO data is not byte-reversed.
- Fault on any of the following: illegal funct3 (011, 110, 111, or 100/101 with a store), any other address, non-word MMIO access, an MMIO store to a load-only address, or a split access whose second beat leaves the RAM region.

Access sizing:
- Size n = 1, 2 or 4 bytes; offset o = `req_addr[1:0]`.
- Split when o + n > 4.
- Beat 0 address = `req_addr & ~3`; beat 1 address = beat 0 address + 4.

Stores:
- Let m = ((1<<n)-1) << o, an 8-bit mask.
- Beat 0: `byte_enable` = m[3:0], `wr_data` = `req_wdata << 8o`.
- Beat 1: `byte_enable` = m[7:4], `wr_data` = `req_wdata >> 8(4-o)`.

Loads:
- Each beat's byte-reversed (RAM) or raw (MMIO) word is captured into a 64-bit buffer: beat 0 in the low half, beat 1 in the high half.
- Result = (buffer >> 8o), low n bytes kept.
- Sign-extended for B/H, zero-extended for BU/HU.

State machine:
- IDLE → BEAT0 on an accepted legal request; IDLE → RESP on an accepted faulting request.
- BEAT0 → BEAT1 if split, otherwise → RESP.
- BEAT1 → RESP.
- RESP → IDLE.
- In BEAT0 and BEAT1 exactly one of `memread`/`memwrite` is high, for one cycle each.
- In all other states: strobes = 0, `byte_enable` = 0, `addr` = 0, `wr_data` = 0.
- Request fields are registered at acceptance; input changes after that have no effect.
- In RESP: `resp_valid` = 1, and `resp_fault` = 1 only for faulted requests.

## Timing
- Reset values: state IDLE, `req_ready` = 1, and 0 on `resp_valid`, `resp_fault`, `resp_rdata`, `memread`, `memwrite`, `byte_enable`, `addr`, `wr_data`.
- Accept on edge k:
  - Beat 0 is driven during cycle k+1.
  - `resp_valid` is high in cycle k+2 for an aligned access, k+3 for a split access, k+1 for a fault.
- Memory samples writes at the end of the beat cycle. Load data is captured at the end of the beat cycle.
- `req_ready` = 0 from BEAT0 through RESP; back-to-back requests are accepted earliest in the cycle after RESP.
- Reset mid-operation: next edge goes to IDLE with no response. A split store already past BEAT0 keeps beat 0 committed and drops beat 1.
- A fault never asserts `memread` or `memwrite`.

## Test plan
- SW 0x12345678 @0x80000010, then LW @0x80000010:
  - SW: `byte_enable` = 1111 for one cycle, `resp_valid` at k+2.
  - LW: returns 0x12345678 with `resp_fault` = 0.
- SB 0x000000AB @0x80000003 (`byte_enable` = 1000, `wr_data` = 0xAB000000), then LB → 0xFFFFFFAB and LBU → 0x000000AB.
- SW 0xDDCCBBAA @0x80000006:
  - Beat 0: `addr` 0x80000004, `byte_enable` 1100, `wr_data` 0xBBAA0000.
  - Beat 1: `addr` 0x80000008, `byte_enable` 0011, `wr_data` 0x0000DDCC.
  - Response at k+3; LW @0x80000006 returns 0xDDCCBBAA.
- MMIO:
  - LW @0x00100000 → 0x17192051, no reversal.
  - SW 0x00005A5A @0x00100014, then LW @0x00100014 → 0x00005A5A.
- Each fault case gives `resp_fault` = 1 at k+1 with no strobes:
  - LH @0x00100002
  - SW @0x00100000
  - LW @0x80000FFE
  - funct3 = 011
  - SBU (store with funct3 100)
- `reset` high during BEAT1 of a split store: only beat 0 lanes change in memory, there is no `resp_valid`, and `req_ready` = 1 the next cycle.

Source files
------------

// File: rtl/load_store_unit_if.sv
// load_store_unit_if
// Bundles the CPU-side request/response handshake and the data-memory bus of
// the load/store unit into one interface.
//   master : the LSU view (takes requests and read data, drives responses and
//            memory strobes/address/write data)
//   slave  : the environment view (CPU execute stage plus data memory)
// Signals:
//   req_valid/req_ready, req_write, req_funct3[2:0], req_addr[31:0],
//   req_wdata[31:0]                     request channel
//   resp_valid, resp_rdata[31:0], resp_fault      response channel
//   memread, memwrite, byte_enable[3:0], addr[31:0], wr_data[31:0]
//                                       memory command
//   mem_out_data[31:0]                  combinational memory read data
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        memread;
  logic        memwrite;
  logic [3:0]  byte_enable;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] mem_out_data;

  modport master (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_out_data,
    output req_ready, resp_valid, resp_rdata, resp_fault,
           memread, memwrite, byte_enable, addr, wr_data
  );

  modport slave (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_out_data,
    input  req_ready, resp_valid, resp_rdata, resp_fault,
           memread, memwrite, byte_enable, addr, wr_data
  );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit
// Initiator side of the data-memory bus. Accepts one RV32 load/store at a
// time, decodes it against the RAM window and the MMIO register set, splits
// misaligned RAM accesses into two word beats, un-swaps RAM read lanes and
// returns a sign/zero-extended result with a one-cycle response pulse.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    load_store_unit_if.master (request, response and memory bus)
// Parameters:
//   RAM_BASE   byte base address of the data RAM
//   RAM_BYTES  size of the data RAM in bytes
module load_store_unit #(
  parameter logic [31:0] RAM_BASE  = 32'h8000_0000,
  parameter int unsigned RAM_BYTES = 4096
) (
  input  logic                      clk,
  input  logic                      reset,
  load_store_unit_if.master         bus
);

  localparam logic [31:0] RAM_LIMIT = 32'(RAM_BYTES);

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, RESP} state_t;

  // RAM read lanes come back reversed: lane 0 sits in bits [31:24].
  function automatic logic [31:0] swap_lanes(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // ---------------------------------------------------------------------
  // Request decode (combinational, from the live request fields)
  // ---------------------------------------------------------------------
  logic [2:0]  n_bytes;
  logic [3:0]  size_mask;
  logic [1:0]  offset;
  logic [3:0]  end_pos;
  logic        split;
  logic [31:0] beat0_addr;
  logic [31:0] beat1_addr;
  logic        ram_hit;
  logic        beat1_in_ram;
  logic        mmio_load_ok;
  logic        mmio_store_ok;
  logic        mmio_ok;
  logic        funct3_ok;
  logic        fault;
  logic [7:0]  lane_mask;
  logic [4:0]  byte_shift;
  logic [5:0]  high_shift;
  logic [31:0] wd0;
  logic [31:0] wd1;

  always_comb begin
    n_bytes   = 3'd4;
    size_mask = 4'b1111;
    case (bus.req_funct3[1:0])
      2'b00: begin
        n_bytes   = 3'd1;
        size_mask = 4'b0001;
      end
      2'b01: begin
        n_bytes   = 3'd2;
        size_mask = 4'b0011;
      end
      default: begin
        n_bytes   = 3'd4;
        size_mask = 4'b1111;
      end
    endcase
  end

  assign offset       = bus.req_addr[1:0];
  assign end_pos      = {2'b00, offset} + {1'b0, n_bytes};
  assign split        = (end_pos > 4'd4);
  assign beat0_addr   = {bus.req_addr[31:2], 2'b00};
  assign beat1_addr   = beat0_addr + 32'd4;
  // Unsigned subtract-and-compare also rejects addresses below the base.
  assign ram_hit      = ((bus.req_addr - RAM_BASE) < RAM_LIMIT);
  assign beat1_in_ram = ((beat1_addr - RAM_BASE) < RAM_LIMIT);

  assign mmio_store_ok = (bus.req_addr == 32'h0010_0014);
  assign mmio_load_ok  = (bus.req_addr == 32'h0010_0000) ||
                         (bus.req_addr == 32'h0010_0004) ||
                         (bus.req_addr == 32'h0010_0010) ||
                         (bus.req_addr == 32'h0010_0014);
  assign mmio_ok       = (bus.req_funct3 == 3'b010) &&
                         (bus.req_write ? mmio_store_ok : mmio_load_ok);

  always_comb begin
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
      3'b100, 3'b101:         funct3_ok = !bus.req_write;
      default:                funct3_ok = 1'b0;
    endcase
  end

  assign fault = !funct3_ok ||
                 (ram_hit ? (split && !beat1_in_ram) : !mmio_ok);

  // Byte-lane mask across both beats; low nibble is beat 0, high is beat 1.
  assign lane_mask  = {4'b0000, size_mask} << offset;
  assign byte_shift = {offset, 3'b000};
  assign high_shift = 6'd32 - {1'b0, byte_shift};
  assign wd0        = bus.req_wdata << byte_shift;
  assign wd1        = bus.req_wdata >> high_shift;

  // ---------------------------------------------------------------------
  // Registered state
  // ---------------------------------------------------------------------
  state_t      state_reg;
  logic        write_reg;
  logic [2:0]  funct3_reg;
  logic [4:0]  byte_shift_reg;
  logic        split_reg;
  logic        ram_reg;
  logic [31:0] beat1_addr_reg;
  logic [3:0]  be1_reg;
  logic [31:0] wd1_reg;
  logic [31:0] buf_lo_reg;

  logic        req_ready_reg;
  logic        resp_valid_reg;
  logic        resp_fault_reg;
  logic [31:0] resp_rdata_reg;
  logic        mem_read_reg;
  logic        mem_write_reg;
  logic [3:0]  byte_enable_reg;
  logic [31:0] addr_reg;
  logic [31:0] wr_data_reg;

  // ---------------------------------------------------------------------
  // Load data path: the current beat's word joins the captured low half,
  // then the 64-bit view is shifted down by the byte offset and extended.
  // ---------------------------------------------------------------------
  logic [31:0] cur_word;
  logic [63:0] load_buf;
  logic [31:0] shifted;
  logic [31:0] load_result;

  assign cur_word = ram_reg ? swap_lanes(bus.mem_out_data) : bus.mem_out_data;
  assign load_buf = (state_reg == BEAT1) ? {cur_word, buf_lo_reg}
                                         : {32'h0000_0000, cur_word};
  assign shifted  = 32'(load_buf >> byte_shift_reg);

  always_comb begin
    case (funct3_reg)
      3'b000:  load_result = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_result = {{16{shifted[15]}}, shifted[15:0]};
      3'b010:  load_result = shifted;
      3'b100:  load_result = {24'h000000, shifted[7:0]};
      3'b101:  load_result = {16'h0000, shifted[15:0]};
      default: load_result = 32'h0000_0000;
    endcase
  end

  // ---------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= IDLE;
      write_reg       <= 1'b0;
      funct3_reg      <= 3'b000;
      byte_shift_reg  <= 5'd0;
      split_reg       <= 1'b0;
      ram_reg         <= 1'b0;
      beat1_addr_reg  <= 32'h0;
      be1_reg         <= 4'h0;
      wd1_reg         <= 32'h0;
      buf_lo_reg      <= 32'h0;
      req_ready_reg   <= 1'b1;
      resp_valid_reg  <= 1'b0;
      resp_fault_reg  <= 1'b0;
      resp_rdata_reg  <= 32'h0;
      mem_read_reg    <= 1'b0;
      mem_write_reg   <= 1'b0;
      byte_enable_reg <= 4'h0;
      addr_reg        <= 32'h0;
      wr_data_reg     <= 32'h0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.req_valid && req_ready_reg) begin
            write_reg      <= bus.req_write;
            funct3_reg     <= bus.req_funct3;
            byte_shift_reg <= byte_shift;
            split_reg      <= split;
            ram_reg        <= ram_hit;
            beat1_addr_reg <= beat1_addr;
            be1_reg        <= bus.req_write ? lane_mask[7:4] : 4'h0;
            wd1_reg        <= bus.req_write ? wd1 : 32'h0;
            req_ready_reg  <= 1'b0;
            if (fault) begin
              // Faults skip the memory entirely and answer next cycle.
              state_reg      <= RESP;
              resp_valid_reg <= 1'b1;
              resp_fault_reg <= 1'b1;
              resp_rdata_reg <= 32'h0;
            end else begin
              state_reg       <= BEAT0;
              mem_read_reg    <= !bus.req_write;
              mem_write_reg   <= bus.req_write;
              addr_reg        <= beat0_addr;
              byte_enable_reg <= bus.req_write ? lane_mask[3:0] : 4'h0;
              wr_data_reg     <= bus.req_write ? wd0 : 32'h0;
            end
          end
        end

        BEAT0: begin
          buf_lo_reg <= cur_word;
          if (split_reg) begin
            state_reg       <= BEAT1;
            addr_reg        <= beat1_addr_reg;
            byte_enable_reg <= be1_reg;
            wr_data_reg     <= wd1_reg;
          end else begin
            state_reg       <= RESP;
            mem_read_reg    <= 1'b0;
            mem_write_reg   <= 1'b0;
            addr_reg        <= 32'h0;
            byte_enable_reg <= 4'h0;
            wr_data_reg     <= 32'h0;
            resp_valid_reg  <= 1'b1;
            resp_fault_reg  <= 1'b0;
            resp_rdata_reg  <= write_reg ? 32'h0 : load_result;
          end
        end

        BEAT1: begin
          state_reg       <= RESP;
          mem_read_reg    <= 1'b0;
          mem_write_reg   <= 1'b0;
          addr_reg        <= 32'h0;
          byte_enable_reg <= 4'h0;
          wr_data_reg     <= 32'h0;
          resp_valid_reg  <= 1'b1;
          resp_fault_reg  <= 1'b0;
          resp_rdata_reg  <= write_reg ? 32'h0 : load_result;
        end

        RESP: begin
          state_reg      <= IDLE;
          resp_valid_reg <= 1'b0;
          resp_fault_reg <= 1'b0;
          req_ready_reg  <= 1'b1;
        end

        default: begin
          state_reg     <= IDLE;
          req_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  // A reset arriving during a beat suppresses that beat's strobe, so memory
  // never commits the beat that the reset is aborting.
  assign bus.memread     = mem_read_reg && !reset;
  assign bus.memwrite    = mem_write_reg && !reset;
  assign bus.byte_enable = byte_enable_reg;
  assign bus.addr        = addr_reg;
  assign bus.wr_data     = wr_data_reg;
  assign bus.req_ready   = req_ready_reg;
  assign bus.resp_valid  = resp_valid_reg;
  assign bus.resp_fault  = resp_fault_reg;
  assign bus.resp_rdata  = resp_rdata_reg;

endmodule
